// File: rtl/sensor_uart_tx_scheduler.sv
// Round-robin scheduler that sends each non-empty sensor FIFO head as a
// two-byte {ID, data} frame on one UART TX valid/ready channel, then pops it.
module sensor_uart_tx_scheduler #(
  parameter int DATA_DEPTH = 8,
  parameter int N_SRC      = 8,
  parameter int SRC_W      = 3,
  parameter int ID_BASE    = 97
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_SRC-1:0]            i_src_enable,
  input  logic [N_SRC-1:0]            i_fifo_data_out_valid_to_extract,
  input  logic [N_SRC*DATA_DEPTH-1:0] i_fifo_data_out,
  output logic [N_SRC-1:0]            o_fifo_data_out_extracted,
  output logic [DATA_DEPTH-1:0]       o_uart_send_data,
  output logic                        o_uart_send_valid,
  input  logic                        i_uart_send_data_ready,
  output logic                        o_busy,
  output logic [SRC_W-1:0]            o_active_src
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND_ID   = 2'd1,
    ST_SEND_DATA = 2'd2,
    ST_POP       = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [SRC_W-1:0]      idx_q, idx_d;
  logic [SRC_W-1:0]      rr_q, rr_d;
  logic [SRC_W-1:0]      active_q, active_d;
  logic [DATA_DEPTH-1:0] word_q, word_d;
  logic [DATA_DEPTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  busy_q, busy_d;
  logic [N_SRC-1:0]      extract_q, extract_d;

  logic [N_SRC-1:0]      req_s;
  logic [SRC_W:0]        cand_s;
  logic                  hit_s;
  logic                  grant_found_s;
  logic [SRC_W-1:0]      grant_idx_s;
  logic [DATA_DEPTH-1:0] grant_word_s;

  function automatic logic [N_SRC-1:0] src_onehot(input logic [SRC_W-1:0] idx);
    return {{(N_SRC-1){1'b0}}, 1'b1} << idx;
  endfunction

  assign req_s = i_fifo_data_out_valid_to_extract & i_src_enable;

  // Round-robin search: first requesting source at or above rr_q, wrapping at N_SRC.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {SRC_W{1'b0}};
    cand_s        = {(SRC_W+1){1'b0}};
    hit_s         = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      cand_s        = {1'b0, rr_q} + (SRC_W+1)'(i);
      cand_s        = (cand_s >= (SRC_W+1)'(N_SRC)) ? cand_s - (SRC_W+1)'(N_SRC) : cand_s;
      hit_s         = req_s[cand_s[SRC_W-1:0]] & ~grant_found_s;
      grant_idx_s   = hit_s ? cand_s[SRC_W-1:0] : grant_idx_s;
      grant_found_s = grant_found_s | hit_s;
    end
  end

  // Head word of the granted source.
  always_comb begin
    grant_word_s = {DATA_DEPTH{1'b0}};
    for (int k = 0; k < N_SRC; k++) begin
      grant_word_s = (grant_idx_s == SRC_W'(k)) ?
                     i_fifo_data_out[k*DATA_DEPTH +: DATA_DEPTH] : grant_word_s;
    end
  end

  // Frame sequencing: next state and next registered outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rr_d       = rr_q;
    active_d   = active_q;
    word_d     = word_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    extract_d  = {N_SRC{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          idx_d      = grant_idx_s;
          active_d   = grant_idx_s;
          word_d     = grant_word_s;
          tx_data_d  = DATA_DEPTH'(ID_BASE) + DATA_DEPTH'(grant_idx_s);
          tx_valid_d = 1'b1;
          state_d    = ST_SEND_ID;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_SEND_ID: begin
        if (i_uart_send_data_ready) begin
          tx_data_d = word_q;
          state_d   = ST_SEND_DATA;
        end else begin
          state_d   = ST_SEND_ID;
        end
      end
      ST_SEND_DATA: begin
        // A FIFO that went empty mid-frame must not be popped.
        if (i_uart_send_data_ready) begin
          tx_valid_d = 1'b0;
          tx_data_d  = {DATA_DEPTH{1'b0}};
          extract_d  = i_fifo_data_out_valid_to_extract & src_onehot(idx_q);
          state_d    = ST_POP;
        end else begin
          state_d    = ST_SEND_DATA;
        end
      end
      ST_POP: begin
        rr_d    = (idx_q == SRC_W'(N_SRC-1)) ? {SRC_W{1'b0}} : idx_q + SRC_W'(1);
        state_d = ST_IDLE;
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= {SRC_W{1'b0}};
      rr_q       <= {SRC_W{1'b0}};
      active_q   <= {SRC_W{1'b0}};
      word_q     <= {DATA_DEPTH{1'b0}};
      tx_data_q  <= {DATA_DEPTH{1'b0}};
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      extract_q  <= {N_SRC{1'b0}};
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rr_q       <= rr_d;
      active_q   <= active_d;
      word_q     <= word_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      extract_q  <= extract_d;
    end
  end

  assign o_fifo_data_out_extracted = extract_q;
  assign o_uart_send_data          = tx_data_q;
  assign o_uart_send_valid         = tx_valid_q;
  assign o_busy                    = busy_q;
  assign o_active_src              = active_q;

endmodule

// File: tb/tb_sensor_uart_tx_scheduler.sv
// Bench for sensor_uart_tx_scheduler: FWFT FIFO stand-ins, a frame-level byte
// queue model of the scheduler, directed scenarios and a randomized run.
module tb_sensor_uart_tx_scheduler;
  localparam int DW  = 8;
  localparam int N   = 8;
  localparam int SW  = 3;
  localparam int IDB = 97;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  en    = '1;
  logic [N-1:0]  fvalid = '0;
  logic [N*DW-1:0] fdata = '0;
  logic          ready = 1'b1;
  logic [N-1:0]  extracted;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          busy;
  logic [SW-1:0] active;

  sensor_uart_tx_scheduler #(
    .DATA_DEPTH(DW), .N_SRC(N), .SRC_W(SW), .ID_BASE(IDB)
  ) dut (
    .i_clk                            (clk),
    .i_rst                            (rst_n),
    .i_src_enable                     (en),
    .i_fifo_data_out_valid_to_extract (fvalid),
    .i_fifo_data_out                  (fdata),
    .o_fifo_data_out_extracted        (extracted),
    .o_uart_send_data                 (tx_data),
    .o_uart_send_valid                (tx_valid),
    .i_uart_send_data_ready           (ready),
    .o_busy                           (busy),
    .o_active_src                     (active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // bench-side FIFOs
  int            cnt[N];
  logic [DW-1:0] head[N];
  logic [N-1:0]  kill = '0;
  int            pops[N];
  logic [DW-1:0] log_q[$];
  bit            rand_ready = 1'b0;

  // model: bytes still owed on the wire for the current frame
  logic [DW-1:0] mq[$];
  int            m_idx = 0;
  int            m_rr = 0;
  bit            m_pop = 1'b0;
  logic [N-1:0]  e_ext = '0;
  int            e_active = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] log_at(input int i);
    return (i < log_q.size()) ? {8'h00, log_q[i]} : 16'hFFFF;
  endfunction

  // reference model
  initial begin
    bit found;
    int c;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_rr = 0; m_idx = 0; m_pop = 1'b0; e_ext = '0; e_active = 0;
      end else begin
        e_ext = '0;
        if (mq.size() > 0) begin
          if (ready) begin
            void'(mq.pop_front());
            if (mq.size() == 0) begin
              e_ext[m_idx] = fvalid[m_idx];
              m_pop = 1'b1;
            end
          end
        end else if (m_pop) begin
          m_pop = 1'b0;
          m_rr = (m_idx + 1) % N;
        end else if ((fvalid & en) != '0) begin
          found = 1'b0;
          for (int i = 0; i < N; i++) begin
            c = (m_rr + i) % N;
            if (!found && fvalid[c] && en[c]) begin
              found = 1'b1;
              m_idx = c;
            end
          end
          mq.push_back(8'(IDB + m_idx));
          mq.push_back(fdata[m_idx*DW +: DW]);
          e_active = m_idx;
        end
      end
    end
  end

  // compare DUT against model every cycle
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("valid", {31'd0, tx_valid}, {31'd0, mq.size() > 0});
        if (mq.size() > 0) check("data", {24'd0, tx_data}, {24'd0, mq[0]});
        check("extract", {24'd0, extracted}, {24'd0, e_ext});
        check("busy", {31'd0, busy}, {31'd0, (mq.size() > 0) || m_pop});
        check("active_src", {29'd0, active}, e_active);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  // one clock: drive FIFO flags, log handshakes, consume pops
  task automatic cycle();
    bit hs;
    logic [DW-1:0] hb;
    for (int k = 0; k < N; k++) begin
      fvalid[k] = (cnt[k] > 0) && !kill[k];
      fdata[k*DW +: DW] = head[k];
    end
    if (rand_ready) ready = 1'($urandom_range(0, 1));
    hs = tx_valid && ready && rst_n;
    hb = tx_data;
    @(posedge clk);
    if (hs) log_q.push_back(hb);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (extracted[k]) begin
        pops[k]++;
        if (cnt[k] > 0) begin
          cnt[k]--;
          head[k] = 8'($urandom);
        end
      end
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    check("rst_extract", {24'd0, extracted}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_active", {29'd0, active}, 32'd0);
    for (int k = 0; k < N; k++) begin
      cnt[k] = 0; pops[k] = 0; head[k] = 8'($urandom);
    end
    kill = '0; en = '1; ready = 1'b1; rand_ready = 1'b0;
    log_q.delete();
    cycles(2);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      cnt[k] = 0; pops[k] = 0; head[k] = '0;
    end
    #1;
    started = 1'b1;
    do_reset();

    // single source, head 0x3C
    cnt[0] = 1; head[0] = 8'h3C;
    cycles(3);
    check("t1_pops", pops[0], 32'd1);
    check("t1_byte0", {16'd0, log_at(0)}, 32'h61);
    check("t1_byte1", {16'd0, log_at(1)}, 32'h3C);
    cycles(5);
    check("t1_pops_idle", pops[0], 32'd1);
    pops[0] = 0; cnt[0] = 3;
    cycles(10);
    check("t1_rate10", pops[0], 32'd2);
    cycle();
    check("t1_rate11", pops[0], 32'd3);
    cycles(2);

    // all sources busy: strict rotation
    do_reset();
    for (int k = 0; k < N; k++) cnt[k] = 100;
    cycles(36);
    check("t2_len", log_q.size(), 32'd18);
    for (int j = 0; j < 9; j++) check("t2_id", {16'd0, log_at(2*j)}, 32'(IDB + (j % N)));
    check("t2_pop0", pops[0], 32'd2);
    for (int k = 1; k < N; k++) check("t2_popk", pops[k], 32'd1);

    // backpressure on both bytes
    do_reset();
    cnt[2] = 1; head[2] = 8'hA5; ready = 1'b0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t3_id_hold_v", {31'd0, tx_valid}, 32'd1);
      check("t3_id_hold_d", {24'd0, tx_data}, 32'h63);
    end
    ready = 1'b1; cycle();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t3_dat_hold_d", {24'd0, tx_data}, 32'hA5);
      check("t3_no_early_pop", pops[2], 32'd0);
    end
    ready = 1'b1; cycle();
    check("t3_pop", pops[2], 32'd1);
    ready = 1'b0; cycles(3);
    check("t3_pop_once", pops[2], 32'd1);
    check("t3_b0", {16'd0, log_at(0)}, 32'h63);
    check("t3_b1", {16'd0, log_at(1)}, 32'hA5);

    // enable mask
    do_reset();
    en = 8'hDF; cnt[1] = 50; cnt[5] = 50;
    cycles(20);
    check("t4_src1", pops[1], 32'd5);
    check("t4_src5_off", pops[5], 32'd0);
    en = 8'hFF;
    cycles(8);
    check("t4_src5_on", pops[5], 32'd1);
    check("t4_src1b", pops[1], 32'd6);

    // reset in SEND_DATA of source 3
    do_reset();
    cnt[3] = 5;
    cycles(2);
    ready = 1'b0;
    check("t5_mid_valid", {31'd0, tx_valid}, 32'd1);
    do_reset();
    check("t5_no_pop", pops[3], 32'd0);
    cnt[0] = 5; cnt[3] = 5;
    cycles(4);
    check("t5_first_src0", {16'd0, log_at(0)}, 32'h61);
    check("t5_src3_unpopped", pops[3], 32'd0);

    // valid drops during SEND_ID
    do_reset();
    cnt[4] = 1; head[4] = 8'h5A; ready = 1'b0;
    cycle();
    kill[4] = 1'b1; ready = 1'b1;
    cycles(6);
    check("t6_b0", {16'd0, log_at(0)}, 32'h65);
    check("t6_b1", {16'd0, log_at(1)}, 32'h5A);
    check("t6_suppressed", pops[4], 32'd0);

    // randomized traffic
    do_reset();
    rand_ready = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) cnt[$urandom_range(0, N-1)] += $urandom_range(1, 4);
      if ($urandom_range(0, 15) == 0) en[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) kill[$urandom_range(0, N-1)] ^= 1'b1;
      if (i == 1000) begin
        do_reset();
        rand_ready = 1'b1;
      end
      cycle();
    end
    rand_ready = 1'b0;
    ready = 1'b1;
    cycles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sensor_uart_tx_scheduler.md
Name: sensor_uart_tx_scheduler

Overview:
- Shares the single UART transmit channel between N_SRC sensor FIFOs.
- Scans the FIFO valid flags with a round-robin arbiter. For each granted FIFO it sends a 2-byte frame: an ID byte (ID_BASE+index), then the FIFO head data byte. It then pops that FIFO with a one-cycle extract pulse.
- Sits between the per-sensor FWFT FIFOs and the UART TX, alongside the command FSM. It provides streaming/autonomous readout without host polling.

Parameters:
DATA_DEPTH, 8, width of FIFO data and UART bytes
N_SRC, 8, number of sensor FIFOs (2..16)
SRC_W, 3, index width, ceil(log2(N_SRC))
ID_BASE, 97, ID byte for source 0 ('a'); ID_BASE+N_SRC-1 must be <= 2^DATA_DEPTH-1

Ports:
i_clk  in  1  system clock, rising edge
i_rst  in  1  asynchronous, active-low reset
i_src_enable  in  N_SRC  per-source enable mask; disabled sources are never granted
i_fifo_data_out_valid_to_extract  in  N_SRC  FWFT FIFO non-empty flags
i_fifo_data_out  in  N_SRC*DATA_DEPTH  FIFO head words; source k uses bits [k*DATA_DEPTH +: DATA_DEPTH]
o_fifo_data_out_extracted  out  N_SRC  one-hot, one-cycle pop pulse
o_uart_send_data  out  DATA_DEPTH  byte to UART TX
o_uart_send_valid  out  1  byte valid
i_uart_send_data_ready  in  1  UART TX accepts the byte when valid && ready
o_busy  out  1  high in any state other than IDLE
o_active_src  out  SRC_W  index of the current or last granted source

Behaviour:
- Registered outputs. States: IDLE, SEND_ID, SEND_DATA, POP.
- Reset (i_rst low, asynchronous):
  - state=IDLE, rr pointer=0.
  - All outputs 0: o_uart_send_valid=0, o_uart_send_data=0, o_fifo_data_out_extracted=0, o_busy=0, o_active_src=0.
  - Reset asserted mid-frame aborts immediately. No pop is issued, and the partial frame is not resumed.
- Request vector: req = i_fifo_data_out_valid_to_extract & i_src_enable.
- IDLE:
  - If req is nonzero, grant the first set bit searching upward from the rr pointer, wrapping at N_SRC-1 to 0.
  - Latch idx; latch the head word i_fifo_data_out[idx] into the data register.
  - Next cycle: state SEND_ID, o_uart_send_valid=1, o_uart_send_data=ID_BASE+idx (modulo 2^DATA_DEPTH, no overflow by parameter rule).
  - If req is zero, stay in IDLE.
- Latency: req seen at edge t, so valid is high after edge t+1.
- SEND_ID:
  - Hold valid and data stable until i_uart_send_data_ready=1.
  - On handshake go to SEND_DATA, data = latched word, valid stays 1 with no bubble.
- SEND_DATA:
  - Hold until ready.
  - On handshake: valid=0, state POP.
  - o_fifo_data_out_extracted[idx]=1 for exactly one cycle, only if i_fifo_data_out_valid_to_extract[idx] is still 1; otherwise the pop is suppressed.
- POP:
  - Clear the extract pulse. rr pointer = idx+1, with N_SRC-1 wrapping to 0. State IDLE.
  - This gives the FIFO one cycle to update its flag before the next arbitration.
- The source is never popped before its data byte handshakes.
- Handshake rules:
  - Valid never deasserts without a handshake, except on reset.
  - Data never changes while valid && !ready.
  - Ready asserted while valid is low is ignored.
- Enable or valid deasserting mid-frame: the frame completes using latched data. Enable changes affect only the next arbitration.
- Fairness: every enabled non-empty source is granted within N_SRC grants.
- Throughput with ready tied high: 1 frame per 4 cycles (IDLE→SEND_ID→SEND_DATA→POP).
- o_active_src updates at grant and holds until the next grant.
- o_busy=0 only in IDLE.

Test Plan:
- Reset, then only FIFO 0 valid with head 0x3C, ready=1 → bytes 0x61, 0x3C on consecutive cycles; extracted[0] pulses once; back to IDLE, 4 cycles per frame.
- All 8 FIFOs valid continuously, ready=1 → ID order 0x61,0x62,…,0x68,0x61; each source popped once per round.
- FIFO 2 valid, ready held low 5 cycles on the ID byte and 3 cycles on the data byte → valid stays high, data stable (0x63 then latched word), exactly one pop after the data handshake.
- FIFOs 1 and 5 valid, enable mask 0xDF → only source 1 granted repeatedly; source 5 never popped; re-enable bit 5 → source 5 served next round.
- Assert i_rst low during SEND_DATA of source 3 → valid drops asynchronously; no extract pulse; after release the first frame comes from source 0 if it is valid.
- FIFO 4 valid drops during SEND_ID → frame still sends 0x65 plus the latched data; extracted[4] suppressed.
